// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//
// Instruction-fetch stage of the 5-stage RV32 core. It owns the program counter
// and drives the fetch->decode pipeline registers fd_pc/fd_instr. It handles
// the I-cache request/miss handshake and raises icache_stall while a miss is
// outstanding. Two free-running performance counters are also kept here.
//
// Ports
//   clock            core clock, all state updates on the rising edge
//   reset            asynchronous, active-low reset
//   load_stall       decode load-use hazard: hold fetch
//   branch_stall     decode branch-operand hazard: hold fetch
//   branch_en        decode: branch taken this cycle
//   branch_PC        redirect target (bits [1:0] are ignored)
//   dcache_stall     global freeze from the memory stage
//   mul_stall        global freeze from the multiplier
//   ic_req           I-cache access valid
//   ic_addr          I-cache access address (always the current pc)
//   ic_hit           same-cycle hit, meaningful while ic_req=1
//   ic_data          instruction word returned on a hit
//   ic_fill_done     one-cycle pulse: the missing line has been installed
//   icache_stall     miss outstanding; freezes decode/execute/memory
//   fd_pc            PC of the instruction presented to decode
//   fd_instr         instruction presented to decode
//   perf_fetched     instructions delivered to fd_* (wraps at 2^32)
//   perf_miss_cycles cycles with icache_stall=1 (wraps at 2^32)
// -----------------------------------------------------------------------------
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] BUBBLE   = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        load_stall,
  input  logic        branch_stall,
  input  logic        branch_en,
  input  logic [31:0] branch_PC,
  input  logic        dcache_stall,
  input  logic        mul_stall,
  output logic        ic_req,
  output logic [31:0] ic_addr,
  input  logic        ic_hit,
  input  logic [31:0] ic_data,
  input  logic        ic_fill_done,
  output logic        icache_stall,
  output logic [31:0] fd_pc,
  output logic [31:0] fd_instr,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_miss_cycles
);

  // Steady-state sequencing. The one-cycle BOOT phase after reset is tracked
  // by a separate flag so the 2-bit state field keeps one spare encoding
  // (2'd3), which is never entered and falls back to RUN.
  typedef enum logic [1:0] {
    RUN       = 2'd0,
    MISS_WAIT = 2'd1,
    REPLAY    = 2'd2
  } state_t;

  state_t      state;
  logic        booting;
  logic [31:0] pc;
  logic        freeze;
  logic        hold;

  assign freeze  = dcache_stall | mul_stall;
  assign hold    = load_stall | branch_stall;
  assign ic_addr = pc;

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path through the case leaves it unassigned and no latch is inferred.
  always_comb begin
    ic_req = 1'b0;
    if (!booting) begin
      case (state)
        RUN:       ic_req = !freeze;
        MISS_WAIT: ic_req = 1'b1;
        default:   ic_req = 1'b0;
      endcase
    end
  end

  // icache_stall is a register that is set on the edge entering MISS_WAIT and
  // cleared on the edge leaving REPLAY, so it has no combinational path from
  // any input and is glitch-free for the stages it freezes.
  //
  // NOTE: all state below uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      booting          <= 1'b1;
      state            <= RUN;
      pc               <= RESET_PC;
      fd_pc            <= 32'h0000_0000;
      fd_instr         <= BUBBLE;
      perf_fetched     <= 32'h0000_0000;
      perf_miss_cycles <= 32'h0000_0000;
      icache_stall     <= 1'b0;
    end else begin
      if (icache_stall) begin
        perf_miss_cycles <= perf_miss_cycles + 32'd1;
      end

      if (booting) begin
        // BOOT: no access this cycle; a late fill pulse is ignored here.
        booting      <= 1'b0;
        state        <= RUN;
        icache_stall <= 1'b0;
      end else begin
        case (state)
          RUN: begin
            if (freeze) begin
              // Whole pipeline frozen: everything holds, redirect ignored.
            end else if (branch_en) begin
              // Redirect overrides hold and any miss on the current pc.
              pc       <= {branch_PC[31:2], 2'b00};
              fd_pc    <= 32'h0000_0000;
              fd_instr <= BUBBLE;
            end else if (hold) begin
              // Decode hazard: hold; a miss now is re-evaluated next cycle.
            end else if (ic_hit) begin
              fd_pc        <= pc;
              fd_instr     <= ic_data;
              pc           <= pc + 32'd4;
              perf_fetched <= perf_fetched + 32'd1;
            end else begin
              state        <= MISS_WAIT;
              icache_stall <= 1'b1;
            end
          end

          MISS_WAIT: begin
            // Decode/freeze inputs are ignored until the line arrives.
            if (ic_fill_done) begin
              state <= REPLAY;
            end
          end

          REPLAY: begin
            // One dead cycle; RUN then re-accesses pc, which now hits.
            state        <= RUN;
            icache_stall <= 1'b0;
          end

          default: begin
            state        <= RUN;
            icache_stall <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
//
// Directed sequence following the fetch-stage bring-up scenarios, followed by
// a randomized phase. Expected values come from a behavioural model of the
// fetch rules (pc, pipeline register contents, counters, miss bookkeeping).
// -----------------------------------------------------------------------------
module tb_fetch_stage;

  localparam logic [31:0] RPC    = 32'h0000_0100;
  localparam logic [31:0] BUBBLE = 32'h0000_0000;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        load_stall = 1'b0;
  logic        branch_stall = 1'b0;
  logic        branch_en = 1'b0;
  logic [31:0] branch_PC = 32'h0;
  logic        dcache_stall = 1'b0;
  logic        mul_stall = 1'b0;
  logic        ic_req;
  logic [31:0] ic_addr;
  logic        ic_hit = 1'b0;
  logic [31:0] ic_data = 32'h0;
  logic        ic_fill_done = 1'b0;
  logic        icache_stall;
  logic [31:0] fd_pc;
  logic [31:0] fd_instr;
  logic [31:0] perf_fetched;
  logic [31:0] perf_miss_cycles;

  fetch_stage #(
    .RESET_PC (RPC),
    .BUBBLE   (BUBBLE)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .load_stall       (load_stall),
    .branch_stall     (branch_stall),
    .branch_en        (branch_en),
    .branch_PC        (branch_PC),
    .dcache_stall     (dcache_stall),
    .mul_stall        (mul_stall),
    .ic_req           (ic_req),
    .ic_addr          (ic_addr),
    .ic_hit           (ic_hit),
    .ic_data          (ic_data),
    .ic_fill_done     (ic_fill_done),
    .icache_stall     (icache_stall),
    .fd_pc            (fd_pc),
    .fd_instr         (fd_instr),
    .perf_fetched     (perf_fetched),
    .perf_miss_cycles (perf_miss_cycles)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_pc, m_fd_pc, m_fd_instr, m_fetched, m_miss;
  bit          m_boot;     // first cycle after reset: no access
  bit          m_waiting;  // miss outstanding, waiting for the fill pulse
  bit          m_replay;   // dead cycle after the fill

  task automatic model_reset();
    m_pc = RPC; m_fd_pc = 32'h0; m_fd_instr = BUBBLE;
    m_fetched = 32'h0; m_miss = 32'h0;
    m_boot = 1'b1; m_waiting = 1'b0; m_replay = 1'b0;
  endtask

  function automatic logic model_req();
    if (m_boot || m_replay) return 1'b0;
    if (m_waiting) return 1'b1;
    return !(dcache_stall || mul_stall);
  endfunction

  // Advance the model by one rising edge using the inputs driven this cycle.
  task automatic model_clock();
    if (m_waiting || m_replay) m_miss = m_miss + 32'd1;
    if (m_boot) begin
      m_boot = 1'b0;
    end else if (m_waiting) begin
      if (ic_fill_done) begin m_waiting = 1'b0; m_replay = 1'b1; end
    end else if (m_replay) begin
      m_replay = 1'b0;
    end else if (dcache_stall || mul_stall) begin
      // frozen
    end else if (branch_en) begin
      m_pc = branch_PC & 32'hFFFF_FFFC;
      m_fd_pc = 32'h0;
      m_fd_instr = BUBBLE;
    end else if (load_stall || branch_stall) begin
      // held
    end else if (ic_hit) begin
      m_fd_pc = m_pc;
      m_fd_instr = ic_data;
      m_pc = m_pc + 32'd4;
      m_fetched = m_fetched + 32'd1;
    end else begin
      m_waiting = 1'b1;
    end
  endtask

  // Called at a falling edge after the inputs for the coming cycle are set.
  task automatic tick();
    #1;
    check("ic_req", ic_req, model_req());
    check("ic_addr", ic_addr, m_pc);
    check("icache_stall", icache_stall, m_waiting || m_replay);
    @(posedge clock);
    model_clock();
    @(negedge clock);
    check("fd_pc", fd_pc, m_fd_pc);
    check("fd_instr", fd_instr, m_fd_instr);
    check("perf_fetched", perf_fetched, m_fetched);
    check("perf_miss_cycles", perf_miss_cycles, m_miss);
  endtask

  task automatic clear_inputs();
    load_stall = 1'b0; branch_stall = 1'b0; branch_en = 1'b0;
    dcache_stall = 1'b0; mul_stall = 1'b0; ic_hit = 1'b0;
    ic_fill_done = 1'b0;
  endtask

  initial begin
    // ---- reset ----
    model_reset();
    repeat (3) @(negedge clock);
    check("rst_ic_req", ic_req, 1'b0);
    check("rst_icache_stall", icache_stall, 1'b0);
    check("rst_fd_instr", fd_instr, 32'h0);
    check("rst_perf_fetched", perf_fetched, 32'h0);
    reset = 1'b1;
    tick();                                   // BOOT cycle
    check("boot_exit_addr", ic_addr, 32'h100);
    check("boot_exit_fd_pc", fd_pc, 32'h0);
    check("boot_exit_miss", perf_miss_cycles, 32'h0);

    // ---- straight-line hits ----
    ic_hit = 1'b1; ic_data = 32'h0050_0093;
    tick();
    check("hit0_fd_pc", fd_pc, 32'h100);
    check("hit0_fd_instr", fd_instr, 32'h0050_0093);
    ic_data = 32'h00a0_0113;
    tick();
    check("hit1_fd_pc", fd_pc, 32'h104);
    check("hit1_fd_instr", fd_instr, 32'h00a0_0113);
    check("hit1_addr", ic_addr, 32'h108);
    check("hit1_fetched", perf_fetched, 32'd2);

    // ---- redirect overrides hold ----
    branch_en = 1'b1; branch_PC = 32'h0000_020E; load_stall = 1'b1;
    tick();
    check("redir_fd_instr", fd_instr, 32'h0);
    check("redir_fd_pc", fd_pc, 32'h0);
    check("redir_addr", ic_addr, 32'h20C);

    // ---- hold then freeze ----
    branch_en = 1'b0; ic_data = 32'hDEAD_BEEF;
    repeat (2) tick();
    load_stall = 1'b0; dcache_stall = 1'b1; branch_en = 1'b1;
    branch_PC = 32'h0000_0400;
    #1 check("freeze_ic_req", ic_req, 1'b0);
    repeat (2) tick();
    check("freeze_addr", ic_addr, 32'h20C);
    check("freeze_fd_pc", fd_pc, 32'h0);
    clear_inputs();

    // ---- miss on 0x20C ----
    tick();                                   // RUN cycle that misses
    check("miss_stall_rise", icache_stall, 1'b1);
    branch_en = 1'b1; load_stall = 1'b1; dcache_stall = 1'b1;
    repeat (5) tick();                        // decode/freeze ignored
    clear_inputs();
    ic_fill_done = 1'b1;
    tick();
    ic_fill_done = 1'b0;
    check("replay_stall", icache_stall, 1'b1);
    tick();                                   // REPLAY
    check("replay_done_stall", icache_stall, 1'b0);
    ic_hit = 1'b1; ic_data = 32'h0000_0513;
    tick();
    check("miss_fd_pc", fd_pc, 32'h20C);
    check("miss_cycles", perf_miss_cycles, 32'd7);

    // ---- pc wrap ----
    branch_en = 1'b1; branch_PC = 32'hFFFF_FFFF;
    tick();
    branch_en = 1'b0;
    tick();
    check("wrap_addr", ic_addr, 32'h0);
    check("wrap_fd_pc", fd_pc, 32'hFFFF_FFFC);

    // ---- reset in the middle of a miss ----
    ic_hit = 1'b0;
    repeat (2) tick();
    check("pre_rst_stall", icache_stall, 1'b1);
    #2 reset = 1'b0;
    #1;
    check("async_rst_stall", icache_stall, 1'b0);
    check("async_rst_addr", ic_addr, RPC);
    model_reset();
    @(negedge clock);
    reset = 1'b1; ic_fill_done = 1'b1;        // stray fill during BOOT
    tick();
    ic_hit = 1'b1; ic_data = 32'h1234_5678;   // and during RUN
    tick();
    check("stray_fill_fd_pc", fd_pc, RPC);
    check("stray_fill_stall", icache_stall, 1'b0);
    clear_inputs();

    // ---- randomized phase ----
    for (int i = 0; i < 400; i++) begin
      dcache_stall = ($urandom_range(0, 9) == 0);
      mul_stall    = ($urandom_range(0, 19) == 0);
      load_stall   = ($urandom_range(0, 9) == 0);
      branch_stall = ($urandom_range(0, 19) == 0);
      branch_en    = ($urandom_range(0, 11) == 0);
      branch_PC    = $urandom;
      ic_hit       = ($urandom_range(0, 3) != 0);
      ic_data      = (m_pc * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
      ic_fill_done = ($urandom_range(0, 3) == 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage RV32 core. It owns the PC and drives the fetch→decode pipeline registers fd_pc/fd_instr.
- Issues requests to the instruction cache and reacts to the decode stage's stall, redirect and bubble signals.
- Generates icache_stall, which freezes every other stage while an I-cache miss is outstanding.
- Also keeps two 32-bit performance counters.

Parameters:
- RESET_PC, 32'h00000000, first PC fetched after reset.
- BUBBLE, 32'h00000000, instruction word injected on squash. Decodes to no write-back, no load, no store.

Ports:
- clock  in  1  core clock; all state on rising edge
- reset  in  1  asynchronous, active-low (0 = reset)
- load_stall  in  1  decode load-use hazard; hold fetch
- branch_stall  in  1  decode branch-operand hazard; hold fetch
- branch_en  in  1  decode: branch taken this cycle
- branch_PC  in  32  redirect target
- dcache_stall  in  1  global freeze from memory stage
- mul_stall  in  1  global freeze from multiplier
- ic_req  out  1  I-cache access valid
- ic_addr  out  32  I-cache access address (= pc)
- ic_hit  in  1  same-cycle hit, valid when ic_req=1
- ic_data  in  32  hit instruction word
- ic_fill_done  in  1  one-cycle pulse: miss line installed
- icache_stall  out  1  miss outstanding; freezes decode/execute/memory
- fd_pc  out  32  PC of instruction presented to decode
- fd_instr  out  32  instruction presented to decode
- perf_fetched  out  32  count of instructions delivered to fd_*
- perf_miss_cycles  out  32  count of cycles with icache_stall=1

Behaviour:
- Reset (reset=0, async):
  - pc=RESET_PC; state=BOOT.
  - fd_pc=0, fd_instr=BUBBLE.
  - perf counters=0; ic_req=0; icache_stall=0.
  - Reset mid-miss abandons the miss. A late ic_fill_done after reset release is ignored in BOOT/RUN.
- Define freeze = dcache_stall | mul_stall. Define hold = load_stall | branch_stall.
- BOOT state:
  - One cycle; ic_req=0.
  - Next state is RUN.
- RUN state:
  - ic_req = !freeze; ic_addr = pc; icache_stall=0.
  - Priority per cycle:
    1. freeze: all registers hold; branch_en ignored.
    2. branch_en: pc<=branch_PC with bits[1:0] forced to 0; fd_pc<=0; fd_instr<=BUBBLE. branch_en wins over hold.
    3. hold: pc, fd_pc and fd_instr hold. A miss during hold is ignored and re-evaluated next cycle.
    4. ic_hit: fd_pc<=pc; fd_instr<=ic_data; pc<=pc+4 (mod 2^32, wraps at 32'hFFFFFFFC→0); perf_fetched++.
    5. miss (ic_hit=0): state<=MISS_WAIT; fd_* and pc hold.
- MISS_WAIT state:
  - ic_req=1; ic_addr=pc; icache_stall=1 (registered state decode, no input combinational path).
  - branch_en, hold and freeze are ignored.
  - On ic_fill_done=1: state<=REPLAY.
- REPLAY state:
  - icache_stall=1; ic_req=0.
  - Next cycle state<=RUN. The RUN access then re-fetches pc and hits.
  - Miss penalty = wait cycles + 2.
- perf_miss_cycles increments every cycle icache_stall=1, including the REPLAY cycle. Both counters wrap at 2^32.
- fd_pc/fd_instr only change on a rising clock edge. They are stable for the whole cycle decode samples them.
- Simultaneous branch_en and miss: the redirect is taken and no miss is entered. The new target is accessed next cycle.
- ic_fill_done while in RUN or BOOT: ignored.
- State encoding: 2 bits. Encoding value 3 is unreachable and must recover to RUN.

Test Plan:
- Reset: hold reset=0 for 3 cycles with RESET_PC=32'h100, then release.
  - Expect BOOT for 1 cycle with ic_req=0.
  - Then ic_addr=32'h100, fd_instr=0, fd_pc=0, both counters 0.
- Straight-line hits: ic_hit=1 with ic_data=32'h00500093 at 0x100 and 32'h00a00113 at 0x104.
  - Expect fd_pc/fd_instr = 0x100/00500093, then 0x104/00a00113.
  - Expect ic_addr=0x108 and perf_fetched=2.
- Redirect: at pc=0x108 assert branch_en=1 with branch_PC=32'h0000020E and load_stall=1 together.
  - Next edge: fd_instr=0, fd_pc=0, ic_addr=0x20C. The load_stall is overridden.
- Hold vs freeze: assert load_stall for 2 cycles, then dcache_stall with branch_en for 2 cycles.
  - Expect pc, fd_pc and fd_instr unchanged throughout.
  - Expect no redirect while frozen, and ic_req=0 during dcache_stall.
- Miss: ic_hit=0 at 0x20C.
  - Expect icache_stall to rise the next cycle.
  - Pulse ic_fill_done 5 cycles later, after which icache_stall stays 1 for 1 more cycle (REPLAY).
  - Then a hit delivers fd_pc=0x20C.
  - Expect perf_miss_cycles=7 and fd_* unchanged during the miss.
- Wrap and reset mid-miss:
  - Set pc to 32'hFFFFFFFC via branch, then hit: expect next ic_addr=0.
  - Enter MISS_WAIT, drive reset=0 asynchronously: expect icache_stall=0 immediately and pc=RESET_PC.
  - Expect a subsequent stray ic_fill_done to be ignored.
